// File: rtl/mc_req_frontend.sv
// Request front-end for the memory controller: buffers host read/write commands
// in an in-order FIFO, issues them as en pulses and returns read data.
module mc_req_frontend #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    mem_en,
  output logic                    mem_w_r,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_e;

  state_e                state_q, state_d;
  cmd_t                  fifo_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      count_q, count_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_w_r_q, mem_w_r_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic full_c, empty_c, push_c, pop_c, can_pop_c;
  cmd_t head_c, req_cmd_c;

  assign full_c    = (count_q == LVL_W'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign push_c    = req_valid && !full_c;
  assign head_c    = fifo_q[rd_ptr_q];
  assign req_cmd_c = '{wr: req_wr, addr: req_addr, data: req_wdata};
  // A read may only leave the FIFO once the response slot is free or draining.
  assign can_pop_c = !empty_c && (head_c.wr || !rsp_valid_q || rsp_ready);

  always_comb begin
    state_d     = state_q;
    pop_c       = 1'b0;
    mem_en_d    = 1'b0;
    mem_w_r_d   = mem_w_r_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (can_pop_c) begin
          pop_c       = 1'b1;
          mem_en_d    = 1'b1;
          mem_w_r_d   = head_c.wr;
          mem_addr_d  = head_c.addr;
          mem_wdata_d = head_c.data;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_w_r_q) begin
          state_d = RD_WAIT;
        end else if (can_pop_c) begin
          pop_c       = 1'b1;
          mem_en_d    = 1'b1;
          mem_w_r_d   = head_c.wr;
          mem_addr_d  = head_c.addr;
          mem_wdata_d = head_c.data;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mem_rdata;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_w_r_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_en_q    <= mem_en_d;
      mem_w_r_q   <= mem_w_r_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= req_cmd_c;
  end

  assign req_ready = !full_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_w_r   = mem_w_r_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign level     = count_q;

endmodule

// File: tb/tb_mc_req_frontend.sv
// Directed bench for mc_req_frontend with a one-cycle-latency memory model.
module tb_mc_req_frontend;

  logic       clk, reset;
  logic       req_valid, req_ready, req_wr;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       mem_en, mem_w_r;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  mem_model [256];
  logic [16:0] cmd_q [$];
  int          cmd_cyc [$];
  logic [7:0]  rsp_q [$];

  mc_req_frontend #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_w_r(mem_w_r), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: samples en at the rising edge, data_out one cycle later.
  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    mem_model[8'h20] = 8'h11;
    mem_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_w_r) mem_model[mem_addr] <= mem_wdata;
      else         mem_rdata <= mem_model[mem_addr];
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (reset && mem_en) begin
      cmd_q.push_back({mem_w_r, mem_addr, mem_wdata});
      cmd_cyc.push_back(cyc);
    end
    if (reset && rsp_valid && rsp_ready) rsp_q.push_back(rsp_rdata);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cmd_q.delete();
    cmd_cyc.delete();
    rsp_q.delete();
  endtask

  // Presents a request and returns just after the edge that accepts it.
  task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d);
    bit acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
      end
    end
    if (!acc) check_eq("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget && rsp_q.size() < n; i++) tick();
  endtask

  initial begin
    logic [16:0] exp_cmd;
    logic [7:0]  exp_rsp [6];
    bit          seen;

    reset = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b0;

    // Reset values before any clock edge.
    #2;
    check_eq("rst_req_ready", 32'(req_ready), 32'(1));
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    check_eq("rst_mem_en",    32'(mem_en),    32'(0));
    check_eq("rst_mem_w_r",   32'(mem_w_r),   32'(0));
    check_eq("rst_mem_addr",  32'(mem_addr),  32'(0));
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    check_eq("rst_level",     32'(level),     32'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Write then read the same address, cycle-exact.
    clear_logs();
    rsp_ready = 1'b1;
    send(1'b1, 8'h10, 8'h5A);
    send(1'b0, 8'h10, 8'h00);
    req_valid = 1'b0;
    check_eq("t2_wr_en",    32'(mem_en),    32'(1));
    check_eq("t2_wr_w_r",   32'(mem_w_r),   32'(1));
    check_eq("t2_wr_addr",  32'(mem_addr),  32'h10);
    check_eq("t2_wr_wdata", 32'(mem_wdata), 32'h5A);
    tick();
    check_eq("t2_rd_en",    32'(mem_en),    32'(1));
    check_eq("t2_rd_w_r",   32'(mem_w_r),   32'(0));
    check_eq("t2_rd_addr",  32'(mem_addr),  32'h10);
    tick();
    check_eq("t2_wait_en",  32'(mem_en),    32'(0));
    check_eq("t2_wait_rsp", 32'(rsp_valid), 32'(0));
    tick();
    check_eq("t2_rsp_valid", 32'(rsp_valid), 32'(1));
    check_eq("t2_rsp_rdata", 32'(rsp_rdata), 32'h5A);
    tick();
    check_eq("t2_rsp_clear", 32'(rsp_valid), 32'(0));
    check_eq("t2_cmd_count", 32'(cmd_q.size()), 32'(2));
    check_eq("t2_rsp_count", 32'(rsp_q.size()), 32'(1));

    // Four back-to-back writes issue on consecutive cycles.
    clear_logs();
    for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 8'(8'hA0 + i));
    req_valid = 1'b0;
    repeat (8) tick();
    check_eq("t3_cmd_count", 32'(cmd_q.size()), 32'(4));
    for (int i = 0; i < 4 && i < cmd_q.size(); i++) begin
      exp_cmd = {1'b1, 8'(i), 8'(8'hA0 + i)};
      check_eq("t3_cmd", 32'(cmd_q[i]), 32'(exp_cmd));
      check_eq("t3_cmd_cycle", 32'(cmd_cyc[i] - cmd_cyc[0]), 32'(i));
    end
    check_eq("t3_no_rsp", 32'(rsp_q.size()), 32'(0));

    // Reads stall behind a held response; FIFO fills, then drains in order.
    clear_logs();
    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, 8'(i), 8'h00);
        req_valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
          if (level == 3'd4) seen = 1'b1;
          else tick();
        end
        check_eq("t4_full_level", 32'(level),     32'(4));
        check_eq("t4_req_ready",  32'(req_ready), 32'(0));
        check_eq("t4_rsp_valid",  32'(rsp_valid), 32'(1));
        check_eq("t4_rsp_first",  32'(rsp_rdata), 32'hA0);
        repeat (3) tick();
        check_eq("t4_stall_level", 32'(level),  32'(4));
        check_eq("t4_stall_en",    32'(mem_en), 32'(0));
        rsp_ready = 1'b1;
      end
    join
    wait_rsp(6, 80);
    repeat (2) tick();
    exp_rsp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00};
    check_eq("t4_rsp_count", 32'(rsp_q.size()), 32'(6));
    for (int i = 0; i < 6 && i < rsp_q.size(); i++)
      check_eq("t4_rsp", 32'(rsp_q[i]), 32'(exp_rsp[i]));
    check_eq("t4_level_empty", 32'(level), 32'(0));

    // Read-write-read to one address keeps order.
    clear_logs();
    send(1'b0, 8'h20, 8'h00);
    send(1'b1, 8'h20, 8'h77);
    send(1'b0, 8'h20, 8'h00);
    req_valid = 1'b0;
    wait_rsp(2, 40);
    check_eq("t5_rsp_count", 32'(rsp_q.size()), 32'(2));
    if (rsp_q.size() >= 2) begin
      check_eq("t5_rsp_old", 32'(rsp_q[0]), 32'h11);
      check_eq("t5_rsp_new", 32'(rsp_q[1]), 32'h77);
    end
    check_eq("t5_cmd_count", 32'(cmd_q.size()), 32'(3));
    if (cmd_q.size() >= 2) check_eq("t5_cmd_wr", 32'(cmd_q[1]), 32'h1_2077);

    // Reset asserted between edges while a read is in RD_WAIT.
    clear_logs();
    send(1'b0, 8'h03, 8'h00);
    req_valid = 1'b0;
    tick();
    check_eq("t6_issue_en",  32'(mem_en),  32'(1));
    check_eq("t6_issue_w_r", 32'(mem_w_r), 32'(0));
    tick();
    check_eq("t6_wait_en",  32'(mem_en),    32'(0));
    check_eq("t6_wait_rsp", 32'(rsp_valid), 32'(0));
    #2 reset = 1'b0;
    #1;
    check_eq("t6_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check_eq("t6_rst_mem_en",    32'(mem_en),    32'(0));
    check_eq("t6_rst_mem_addr",  32'(mem_addr),  32'(0));
    check_eq("t6_rst_req_ready", 32'(req_ready), 32'(1));
    check_eq("t6_rst_level",     32'(level),     32'(0));
    tick();
    check_eq("t6_rst_hold_rsp",  32'(rsp_valid), 32'(0));
    reset = 1'b1;
    repeat (3) tick();
    check_eq("t6_no_stale", 32'(rsp_q.size()), 32'(0));
    send(1'b0, 8'h02, 8'h00);
    req_valid = 1'b0;
    wait_rsp(1, 20);
    check_eq("t6_new_count", 32'(rsp_q.size()), 32'(1));
    if (rsp_q.size() >= 1) check_eq("t6_new_rdata", 32'(rsp_q[0]), 32'hA2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_req_frontend.md
Name: mc_req_frontend

Overview:
- Request front-end that sits directly upstream of the memory controller and drives its en / w_r / addr / in_data inputs.
- Accepts host read/write requests over a valid/ready interface and buffers them in a small in-order command FIFO.
- Issues each command to the memory controller as a single-cycle en pulse.
- Captures read data on the controller's one-cycle read latency and returns it over a valid/ready response interface.

Parameters:
- DATA_WIDTH, 8, width of write and read data.
- ADDR_WIDTH, 8, width of memory address.
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  request accepted when high; equals !fifo_full.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  output  1  read response valid.
- rsp_ready  input  1  host accepts response.
- rsp_rdata  output  DATA_WIDTH  read data.
- mem_en  output  1  to controller en.
- mem_w_r  output  1  to controller w_r.
- mem_addr  output  ADDR_WIDTH  to controller wr_addr.
- mem_wdata  output  DATA_WIDTH  to controller in_data.
- mem_rdata  input  DATA_WIDTH  from controller data_out.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous, active-low (reset=0), taking effect immediately without a clock edge.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, mem_en=0, mem_w_r=0, mem_addr=0, mem_wdata=0, level=0.
  - FIFO pointers cleared; FSM goes to IDLE.
  - Reset mid-operation drops all queued commands and any in-flight read with no response.
- Push: on an edge with req_valid && req_ready, {req_wr, req_addr, req_wdata} is written to the FIFO tail. There is no bypass when full; req_ready is combinational !full.
- Pop eligibility ("can_pop"):
  - FIFO non-empty, and
  - head is a write, or (!rsp_valid || rsp_ready).
- Simultaneous push and pop in the same cycle is legal; level is unchanged.
- All mem_* outputs are registered.
- FSM states: IDLE, ISSUE, RD_WAIT.
  - IDLE:
    - mem_en=0.
    - If can_pop: pop the head, load mem_w_r/mem_addr/mem_wdata, set mem_en=1, go to ISSUE.
  - ISSUE (mem_en=1 for this cycle; the controller samples at the next edge):
    - If the current command is a read: mem_en←0, go to RD_WAIT.
    - If it is a write and can_pop: pop the next command, stay in ISSUE (back-to-back, one write per cycle).
    - Otherwise: mem_en←0, go to IDLE.
  - RD_WAIT:
    - mem_rdata is valid this cycle. At the edge: rsp_rdata←mem_rdata, rsp_valid←1, go to IDLE.
    - No pop occurs in RD_WAIT.
- Response slot: rsp_valid clears on an edge with rsp_ready=1 and no new capture. A capture and a drain on the same edge leaves rsp_valid=1 with the new data.
- Latency from an empty, idle state, with request accepted at edge E0:
  - E1: pop; mem_en high during the following cycle.
  - E2: controller samples (write committed / data_out loaded).
  - E3 (reads): rsp_valid=1.
- Throughput: 1 write per cycle; 1 read per 3 cycles.
- Ordering is strictly in order. A read issued before a write to the same address returns the old data.
- A read stalls at the FIFO head while the response slot is full and not draining. Later commands, including writes, wait behind it.
- Widths: address and data pass through unmodified; no arithmetic beyond pointer wrap modulo DEPTH. level ranges 0..DEPTH.

Test Plan:
1. Hold reset=0 mid-cycle with no clock -> all outputs at reset values immediately; req_ready=1, level=0.
2. Write addr 0x10 data 0x5A, then read 0x10, rsp_ready=1 -> mem_en pulses once per command with mem_w_r=1 then 0; rsp_valid for one cycle with rsp_rdata=0x5A.
3. Four writes to 0x00..0x03 (data 0xA0..0xA3) on consecutive cycles -> mem_en high 4 consecutive cycles with addresses 0x00..0x03 in order; no rsp_valid.
4. rsp_ready=0; send reads to 0x00..0x05 continuously -> the first read completes (rsp_valid=1, 0xA0); the next pop blocks; req_ready drops after the FIFO fills (level=4). Then set rsp_ready=1 -> responses 0xA1..0xA3 etc. arrive in order, level returns to 0.
5. Read 0x20 then write 0x20=0x77 then read 0x20 (initial 0x11) -> responses 0x11 then 0x77, in order.
6. Assert reset=0 during RD_WAIT of a read -> rsp_valid stays 0 and mem_en=0; after release, no stale response, and a new read returns correct data.
